// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches. Checks each resolve against the oldest prediction,
// drives predictor update pulses, and on a mispredict flushes, redirects and blocks enqueue.
module branch_resolve_queue #(
  parameter int unsigned PC_WIDTH       = 64,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned PTR_W          = 2,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pred_valid,
  output logic                pred_ready,
  input  logic [PC_WIDTH-1:0] pred_pc,
  input  logic                pred_taken,
  input  logic [PC_WIDTH-1:0] pred_target,
  input  logic                res_valid,
  input  logic [PC_WIDTH-1:0] res_pc,
  input  logic                res_taken,
  input  logic [PC_WIDTH-1:0] res_target,
  output logic                branch_taken,
  output logic                branch_not_taken,
  output logic [PC_WIDTH-1:0] branch_pc,
  output logic [PC_WIDTH-1:0] branch_address,
  output logic                flush,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PTR_W:0]      count,
  output logic                err
);

  localparam int unsigned RcW = $clog2(RECOVER_CYCLES + 1);

  localparam logic [0:0] StRun     = 1'b0;
  localparam logic [0:0] StRecover = 1'b1;

  logic [PC_WIDTH-1:0] pc_mem     [DEPTH];
  logic                taken_mem  [DEPTH];
  logic [PC_WIDTH-1:0] target_mem [DEPTH];

  logic [0:0]          state_q, state_d;
  logic [RcW-1:0]      rc_q, rc_d;
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                err_q, err_d;
  logic                flush_q, flush_d;
  logic [PC_WIDTH-1:0] redirect_q, redirect_d;
  logic                bt_q, bt_d, bnt_q, bnt_d;
  logic [PC_WIDTH-1:0] bpc_q, bpc_d, baddr_q, baddr_d;

  logic                enq, res_run, res_proc, mispredict, pop, mem_we;
  logic [PC_WIDTH-1:0] head_pc, head_target, correct_pc;
  logic                head_taken;

  assign pred_ready = (state_q == StRun) && (count_q < (PTR_W + 1)'(DEPTH));

  always_comb begin
    enq         = pred_valid && pred_ready;
    res_run     = res_valid && (state_q == StRun);
    res_proc    = res_run && (count_q != '0);
    head_pc     = pc_mem[head_q];
    head_taken  = taken_mem[head_q];
    head_target = target_mem[head_q];
    mispredict  = res_proc && ((head_taken != res_taken) ||
                               (res_taken && (head_target != res_target)));
    pop         = res_proc && !mispredict;
    correct_pc  = res_taken ? res_target : res_pc + PC_WIDTH'(1);
    // A mispredict squashes the same-cycle enqueue along with everything else.
    mem_we      = enq && !mispredict;
  end

  always_comb begin
    head_d     = head_q + PTR_W'(pop);
    tail_d     = tail_q + PTR_W'(mem_we);
    count_d    = count_q + (PTR_W + 1)'(mem_we) - (PTR_W + 1)'(pop);
    state_d    = state_q;
    rc_d       = rc_q;
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    case (state_q)
      StRun: begin
        if (mispredict) begin
          state_d = StRecover;
          rc_d    = RcW'(RECOVER_CYCLES);
        end
      end
      StRecover: begin
        if (rc_q == RcW'(1)) begin
          state_d = StRun;
          rc_d    = '0;
        end else begin
          rc_d = rc_q - RcW'(1);
        end
      end
      default: state_d = StRun;
    endcase

    flush_d    = mispredict;
    redirect_d = mispredict ? correct_pc : redirect_q;
    bt_d       = res_proc && res_taken;
    bnt_d      = res_proc && !res_taken;
    bpc_d      = res_proc ? res_pc : bpc_q;
    baddr_d    = res_proc ? res_target : baddr_q;
    err_d      = err_q || (res_run && (count_q == '0)) || (res_proc && (res_pc != head_pc));
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      pc_mem[tail_q]     <= pred_pc;
      taken_mem[tail_q]  <= pred_taken;
      target_mem[tail_q] <= pred_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      rc_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      bt_q       <= 1'b0;
      bnt_q      <= 1'b0;
      bpc_q      <= '0;
      baddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      rc_q       <= rc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      err_q      <= err_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      bt_q       <= bt_d;
      bnt_q      <= bnt_d;
      bpc_q      <= bpc_d;
      baddr_q    <= baddr_d;
    end
  end

  assign branch_taken     = bt_q;
  assign branch_not_taken = bnt_q;
  assign branch_pc        = bpc_q;
  assign branch_address   = baddr_q;
  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign count            = count_q;
  assign err              = err_q;

endmodule
